mdu_iter_core: RTL and testbench

Iterative multiply/divide engine that sits directly below MDU in the E stage. MDU issues operands and an operation on `start`. The engine computes a 64-bit {hi,lo} result over multiple cycles and returns it with a one-cycle `done` pulse; MDU then commits the result to its HI/LO registers. This replaces behavioural `*`, `/` and `%` with a bit-serial shift-add multiplier and restoring divider, and honours the exception/interrupt cancel (`abort`, driven from `req`).

---
 rtl/mdu_iter_core.sv | 173 +++++++++++++++++
 tb/tb_mdu_iter_core.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - iterative shift-add multiplier / restoring divider for the MDU
module mdu_iter_core #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);

    localparam int N = 32 / STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    // acc[64:32] holds the running high half (product) or remainder (divide);
    // acc[31:0] holds the multiplier bits still to consume, or dividend/quotient.
    logic [64:0] acc;
    logic [64:0] acc_next;
    // Multiplicand for multiply, divisor for divide; 33 bits so |0x80000000| fits.
    logic [32:0] opnd;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;

    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // One radix-2 step: shift-add for multiply, shift/trial-subtract for divide
    function automatic logic [64:0] iter_step(input logic [64:0] x,
                                              input logic [32:0] d,
                                              input logic        div);
        logic [33:0] sum;
        logic [32:0] rem_sh;
        logic [33:0] diff;
        logic [64:0] res;
        sum    = {1'b0, x[64:32]} + (x[0] ? {1'b0, d} : 34'd0);
        rem_sh = x[63:31];
        diff   = {1'b0, rem_sh} - {1'b0, d};
        if (div) begin
            if (!diff[33]) begin
                res = {diff[32:0], x[30:0], 1'b1};
            end else begin
                res = {rem_sh, x[30:0], 1'b0};
            end
        end else begin
            res = {sum, x[31:1]};
        end
        return res;
    endfunction

    // Operand magnitudes and sign flags for the op being offered on the inputs
    always_comb begin
        op_signed = ~op[0];
        a_neg     = op_signed & a[31];
        b_neg     = op_signed & b[31];
        a_mag     = a_neg ? (32'd0 - a) : a;
        b_mag     = b_neg ? (32'd0 - b) : b;
    end

    // STEP iterations chained combinationally per cycle
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < STEP; i++) begin
            acc_next = iter_step(acc_next, opnd, is_div);
        end
    end

    // Two's-complement correction of the unsigned result
    always_comb begin
        prod_fix = neg_q ? (64'd0 - acc[63:0]) : acc[63:0];
        quo_fix  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // Control FSM with registered busy/done/hi/lo/dz
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            dz     <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 6'd0;
            acc    <= 65'd0;
            opnd   <= 33'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start && !abort) begin
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (op[1] && (b == 32'd0)) begin
                            // Divide by zero completes immediately; hi/lo keep old values
                            dz    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            acc   <= {33'd0, (op[1] ? a_mag : b_mag)};
                            opnd  <= {1'b0, (op[1] ? b_mag : a_mag)};
                            cnt   <= 6'(N);
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            state <= SIGN;
                        end
                    end
                end
                SIGN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                        dz    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter_core.sv
// tb/tb_mdu_iter_core.sv - scoreboard bench for mdu_iter_core at STEP 1, 2 and 4
module tb_mdu_iter_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;

    logic        busy_w [3];
    logic        done_w [3];
    logic        dz_w   [3];
    logic [31:0] hi_w   [3];
    logic [31:0] lo_w   [3];

    typedef struct {
        int          inst;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          edge_n;
    } exp_t;

    exp_t        expq[$];

    int          tests;
    int          fails;
    int          e_cnt;
    bit          end_req;

    bit          infl  [3];
    int          fin_e [3];
    logic [63:0] pend  [3];
    logic [31:0] m_hi  [3];
    logic [31:0] m_lo  [3];
    logic        m_dz  [3];

    genvar gk;
    for (gk = 0; gk < 3; gk++) begin : g_dut
        mdu_iter_core #(.STEP(1 << gk)) u_dut (
            .clk   (clk),
            .reset (reset),
            .start (start),
            .op    (op),
            .a     (a),
            .b     (b),
            .abort (abort),
            .busy  (busy_w[gk]),
            .done  (done_w[gk]),
            .hi    (hi_w[gk]),
            .lo    (lo_w[gk]),
            .dz    (dz_w[gk])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result {hi, lo} straight from integer arithmetic
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint          q;
        longint          r;
        longint unsigned ux;
        longint unsigned uy;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: res = 64'(sx * sy);
            2'd1: res = 64'(ux * uy);
            2'd2: begin
                q   = sx / sy;
                r   = sx % sy;
                res = {r[31:0], q[31:0]};
            end
            default: begin
                uq  = ux / uy;
                ur  = ux % uy;
                res = {ur[31:0], uq[31:0]};
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic push_exp(input int k, input logic [31:0] h, input logic [31:0] l,
                            input logic z, input int en);
        exp_t t;
        t.inst   = k;
        t.hi     = h;
        t.lo     = l;
        t.dz     = z;
        t.edge_n = en;
        expq.push_back(t);
    endtask

    task automatic drop_last(input int k);
        bit found;
        found = 1'b0;
        for (int i = expq.size() - 1; i >= 0; i--) begin
            if (!found && expq[i].inst == k) begin
                expq.delete(i);
                found = 1'b1;
            end
        end
    endtask

    // Behavioural model: tracks, per instance, when the engine is free and what it will report
    initial begin
        e_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            infl[k]  = 1'b0;
            fin_e[k] = 0;
            pend[k]  = 64'd0;
            m_hi[k]  = 32'd0;
            m_lo[k]  = 32'd0;
            m_dz[k]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            e_cnt++;
            for (int k = 0; k < 3; k++) begin
                if (reset) begin
                    if (infl[k]) drop_last(k);
                    infl[k] = 1'b0;
                    m_hi[k] = 32'd0;
                    m_lo[k] = 32'd0;
                    m_dz[k] = 1'b0;
                end else if (infl[k]) begin
                    if (abort) begin
                        drop_last(k);
                        infl[k] = 1'b0;
                    end else if (e_cnt == fin_e[k]) begin
                        m_hi[k] = pend[k][63:32];
                        m_lo[k] = pend[k][31:0];
                        m_dz[k] = 1'b0;
                        infl[k] = 1'b0;
                    end
                end else if (start && !abort) begin
                    if (op[1] && b == 32'd0) begin
                        m_dz[k] = 1'b1;
                        push_exp(k, m_hi[k], m_lo[k], 1'b1, e_cnt);
                    end else begin
                        pend[k]  = ref_res(op, a, b);
                        fin_e[k] = e_cnt + (32 >> k) + 1;
                        infl[k]  = 1'b1;
                        push_exp(k, pend[k][63:32], pend[k][31:0], 1'b0, fin_e[k]);
                    end
                end
            end
        end
    end

    // Monitor: every cycle compare visible state, and pop/check each done pulse
    initial begin
        tests = 0;
        fails = 0;
        forever begin
            @(negedge clk);
            if (end_req) begin
                for (int i = 0; i < expq.size(); i++) begin
                    tests++;
                    fails++;
                    $display("FAIL pending_done inst %0d: no done seen, required at edge %0d hi=%08h lo=%08h",
                             expq[i].inst, expq[i].edge_n, expq[i].hi, expq[i].lo);
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
            for (int k = 0; k < 3; k++) begin
                int idx;
                tests++;
                if ({busy_w[k], dz_w[k], hi_w[k], lo_w[k]} !== {infl[k], m_dz[k], m_hi[k], m_lo[k]}) begin
                    fails++;
                    $display("FAIL state inst %0d edge %0d: got busy=%b dz=%b hi=%08h lo=%08h, required busy=%b dz=%b hi=%08h lo=%08h",
                             k, e_cnt, busy_w[k], dz_w[k], hi_w[k], lo_w[k],
                             infl[k], m_dz[k], m_hi[k], m_lo[k]);
                end
                idx = -1;
                for (int i = 0; i < expq.size(); i++) begin
                    if (idx < 0 && expq[i].inst == k) idx = i;
                end
                if (done_w[k] === 1'b1) begin
                    tests++;
                    if (idx < 0) begin
                        fails++;
                        $display("FAIL done_unexpected inst %0d edge %0d: got done=1, required done=0", k, e_cnt);
                    end else begin
                        if (expq[idx].edge_n != e_cnt || hi_w[k] !== expq[idx].hi ||
                            lo_w[k] !== expq[idx].lo || dz_w[k] !== expq[idx].dz) begin
                            fails++;
                            $display("FAIL result inst %0d: got edge=%0d hi=%08h lo=%08h dz=%b, required edge=%0d hi=%08h lo=%08h dz=%b",
                                     k, e_cnt, hi_w[k], lo_w[k], dz_w[k],
                                     expq[idx].edge_n, expq[idx].hi, expq[idx].lo, expq[idx].dz);
                        end
                        expq.delete(idx);
                    end
                end else if (idx >= 0 && expq[idx].edge_n < e_cnt) begin
                    tests++;
                    fails++;
                    $display("FAIL done_missing inst %0d: got done=%b at edge %0d, required done=1 at edge %0d",
                             k, done_w[k], e_cnt, expq[idx].edge_n);
                    expq.delete(idx);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
    endtask

    // Stimulus: directed sequences followed by a random phase
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        op      = 2'd0;
        a       = 32'd0;
        b       = 32'd0;
        end_req = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        issue(2'd0, 32'hFFFF_FFFE, 32'd3);
        cyc(36);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc(36);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc(36);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        cyc(36);
        issue(2'd3, 32'd7, 32'd2);
        cyc(36);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        cyc(36);
        issue(2'd2, 32'd5, 32'd0);
        cyc(3);
        issue(2'd0, 32'd2, 32'd2);
        cyc(36);

        // Abort mid-calculation, then a start right after
        issue(2'd1, $urandom, $urandom);
        cyc(8);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        issue(2'd1, $urandom, $urandom);
        cyc(40);

        // Reset mid-calculation
        issue(2'd1, $urandom, $urandom);
        cyc(8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(40);

        // start together with abort while idle is refused
        abort = 1'b1;
        issue(2'd0, 32'd9, 32'd9);
        abort = 1'b0;
        cyc(3);

        // A start pulse while busy is ignored
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        cyc(5);
        issue(2'd3, 32'd100, 32'd7);
        cyc(40);

        // start held high with alternating ops
        start = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 2'(i);
            a  = $urandom;
            b  = (i % 7 == 0) ? 32'd0 : $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        cyc(40);

        // Random phase with occasional abort and reset
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 499) == 0);
            op    = 2'($urandom);
            a     = pick_val();
            b     = pick_val();
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        cyc(45);
        end_req = 1'b1;
        cyc(5);
    end

endmodule
